// File: rtl/pad_poller_pkg.sv
// Shared definitions for the serial game-pad poller.
//   state_e          : poll sequencer states
//   DEF_*            : default parameter values for pad_poller
//   clog2_min1()     : counter width helper that never returns 0
package pad_poller_pkg;

   // state    | meaning
   // IDLE     | waiting for a start/auto request or a pending one
   // LATCH    | pad_latch high for two tick periods
   // SETTLE   | latch released, bit 0 sampled at the end
   // CLK_LO   | pad_clk low for one tick period
   // CLK_HI   | pad_clk high, next bit sampled at the end
   // FINISH   | publish captured state, pulse done
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LATCH  = 3'd1,
      SETTLE = 3'd2,
      CLK_LO = 3'd3,
      CLK_HI = 3'd4,
      FINISH = 3'd5
   } state_e;

   localparam int DEF_CHANNELS    = 2;
   localparam int DEF_BITS        = 8;
   localparam int DEF_CLK_DIV     = 6;
   localparam int DEF_AUTO_PERIOD = 16384;

   // Width needed to hold 0..n-1, with a floor of one bit so a
   // divide-by-one or single-value counter still has a real register.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pad_tick_div.sv
// Phase timer for the pad poller.
// Emits tick_o on the last cycle of every CLK_DIV-cycle phase. The
// count restarts whenever the sequencer changes state so each state
// begins a fresh phase.
//   clk_i      : system clock
//   reset_i    : asynchronous active-high reset
//   restart_i  : high on the cycle the sequencer moves to a new state
//   tick_o     : high on the final cycle of the current phase
module pad_tick_div
   import pad_poller_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic restart_i,
   output logic tick_o
);

   localparam int              CW      = clog2_min1(CLK_DIV);
   localparam logic [CW-1:0]   TC_LOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Down-counter: load CLK_DIV-1, tick at terminal count zero.
   always_comb begin
      cnt_d = cnt_q;
      if (restart_i || (cnt_q == '0)) begin
         cnt_d = TC_LOAD;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   assign tick_o = (cnt_q == '0);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= TC_LOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pad_poller.sv
// Polls CHANNELS NES/SNES style serial game pads in parallel.
// A poll latches the pads, shifts BITS bits out of each one and then
// publishes the inverted (1 = pressed) state of every pad at once.
//   clk        : system clock
//   reset      : asynchronous active-high reset
//   start      : single-cycle poll request
//   ack        : per-channel clear of changed
//   pad_data   : serial data from each pad (active low)
//   pad_latch  : latch strobe to all pads
//   pad_clk    : shift clock to all pads, idles high
//   busy       : poll sequence in progress
//   done       : one-cycle pulse when a poll completes
//   state_flat : button state, channel c at [c*BITS +: BITS]
//   changed    : sticky per-channel change flag
module pad_poller
   import pad_poller_pkg::*;
#(
   parameter int CHANNELS    = DEF_CHANNELS,
   parameter int BITS        = DEF_BITS,
   parameter int CLK_DIV     = DEF_CLK_DIV,
   parameter int AUTO_PERIOD = DEF_AUTO_PERIOD
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [CHANNELS-1:0]      ack,
   input  logic [CHANNELS-1:0]      pad_data,
   output logic                     pad_latch,
   output logic                     pad_clk,
   output logic                     busy,
   output logic                     done,
   output logic [CHANNELS*BITS-1:0] state_flat,
   output logic [CHANNELS-1:0]      changed
);

   localparam int            BCW      = clog2_min1(BITS);
   localparam logic [BCW-1:0] BIT_LAST = BCW'(BITS - 1);

   state_e                   state_q, state_d;
   logic                     lat_half_q, lat_half_d;
   logic [BCW-1:0]           bit_q, bit_d;
   logic                     pending_q, pending_d;
   logic [CHANNELS*BITS-1:0] sreg_q, sreg_d;
   logic [CHANNELS*BITS-1:0] flat_q, flat_d;
   logic [CHANNELS-1:0]      changed_q, changed_d;
   logic                     pad_latch_q, pad_latch_d;
   logic                     pad_clk_q, pad_clk_d;

   logic tick;
   logic restart;
   logic capture;
   logic auto_req;
   logic req;

   pad_tick_div #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk_i     (clk),
      .reset_i   (reset),
      .restart_i (restart),
      .tick_o    (tick)
   );

   assign restart = (state_d != state_q);

   // Free-running request timer; a request fires on the wrap cycle.
   generate
      if (AUTO_PERIOD > 0) begin : g_auto
         localparam int            AW        = clog2_min1(AUTO_PERIOD);
         localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);

         logic [AW-1:0] auto_q, auto_d;

         assign auto_req = (auto_q == AUTO_LAST);
         assign auto_d   = auto_req ? '0 : auto_q + 1'b1;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               auto_q <= '0;
            end else begin
               auto_q <= auto_d;
            end
         end
      end else begin : g_no_auto
         assign auto_req = 1'b0;
      end
   endgenerate

   // A start and an auto request in the same cycle are one request.
   assign req = start | auto_req;

   // Sequencer next state and combinational outputs.
   always_comb begin
      state_d    = state_q;
      lat_half_d = lat_half_q;
      bit_d      = bit_q;
      capture    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;

      case (state_q)
         IDLE: begin
            lat_half_d = 1'b0;
            if (req || pending_q) begin
               state_d = LATCH;
            end
         end
         LATCH: begin
            busy = 1'b1;
            // Latch spans two tick periods; the first tick only arms.
            if (tick) begin
               if (lat_half_q) begin
                  state_d = SETTLE;
               end else begin
                  lat_half_d = 1'b1;
               end
            end
         end
         SETTLE: begin
            busy = 1'b1;
            if (tick) begin
               capture = 1'b1;
               bit_d   = BCW'(1);
               state_d = CLK_LO;
            end
         end
         CLK_LO: begin
            busy = 1'b1;
            if (tick) begin
               state_d = CLK_HI;
            end
         end
         CLK_HI: begin
            busy = 1'b1;
            if (tick) begin
               capture = 1'b1;
               if (bit_q == BIT_LAST) begin
                  state_d = FINISH;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  state_d = CLK_LO;
               end
            end
         end
         FINISH: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Pad pins are registered from the next state so they never glitch.
   assign pad_latch_d = (state_d == LATCH);
   assign pad_clk_d   = (state_d != CLK_LO);

   // One-deep request memory; cleared on the edge that leaves IDLE.
   always_comb begin
      pending_d = pending_q;
      if (state_q == IDLE) begin
         pending_d = 1'b0;
      end else if (req) begin
         pending_d = 1'b1;
      end
   end

   // Right-shifting capture: after BITS shifts the first bit out of the
   // pad sits at the LSB. Data is inverted so 1 = pressed.
   always_comb begin
      sreg_d = sreg_q;
      if (capture) begin
         for (int c = 0; c < CHANNELS; c++) begin
            sreg_d[c*BITS +: BITS] = {~pad_data[c], sreg_q[c*BITS+1 +: BITS-1]};
         end
      end
   end

   // Publish and change detect; a set in FINISH overrides a same-cycle ack.
   always_comb begin
      flat_d    = flat_q;
      changed_d = changed_q & ~ack;
      if (state_q == FINISH) begin
         flat_d = sreg_q;
         for (int c = 0; c < CHANNELS; c++) begin
            if (sreg_q[c*BITS +: BITS] != flat_q[c*BITS +: BITS]) begin
               changed_d[c] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         lat_half_q  <= 1'b0;
         bit_q       <= '0;
         pending_q   <= 1'b0;
         sreg_q      <= '0;
         flat_q      <= '0;
         changed_q   <= '0;
         pad_latch_q <= 1'b0;
         pad_clk_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         lat_half_q  <= lat_half_d;
         bit_q       <= bit_d;
         pending_q   <= pending_d;
         sreg_q      <= sreg_d;
         flat_q      <= flat_d;
         changed_q   <= changed_d;
         pad_latch_q <= pad_latch_d;
         pad_clk_q   <= pad_clk_d;
      end
   end

   assign pad_latch  = pad_latch_q;
   assign pad_clk    = pad_clk_q;
   assign state_flat = flat_q;
   assign changed    = changed_q;

endmodule

// File: tb/tb_pad_poller.sv
module tb_pad_poller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic flag_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: got timeout/unexpected event expected none", name);
   endtask

   // ---------------- instance A: default parameters ----------------
   logic             a_reset = 1'b0, a_start = 1'b0;
   logic [1:0]       a_ack = '0, a_pad;
   logic             a_latch, a_pclk, a_busy, a_done;
   logic [15:0]      a_flat;
   logic [1:0]       a_chg;
   logic [1:0][7:0]  a_raw = '1;
   logic [1:0][7:0]  a_sh  = '1;

   pad_poller dut_a (
      .clk(clk), .reset(a_reset), .start(a_start), .ack(a_ack), .pad_data(a_pad),
      .pad_latch(a_latch), .pad_clk(a_pclk), .busy(a_busy), .done(a_done),
      .state_flat(a_flat), .changed(a_chg)
   );

   always @(posedge a_pclk or posedge a_latch)
      for (int c = 0; c < 2; c++)
         if (a_latch) a_sh[c] <= a_raw[c];
         else         a_sh[c] <= {1'b1, a_sh[c][7:1]};
   assign a_pad = {a_sh[1][0], a_sh[0][0]};

   // ---------------- instance B: 4 x 16 bits, divide by 1 ----------------
   logic              b_reset = 1'b0, b_start = 1'b0;
   logic [3:0]        b_ack = '0, b_pad;
   logic              b_latch, b_pclk, b_busy, b_done;
   logic [63:0]       b_flat;
   logic [3:0]        b_chg;
   logic [3:0][15:0]  b_raw = '1;
   logic [3:0][15:0]  b_sh  = '1;
   int                b_lo_cnt = 0;

   pad_poller #(.CHANNELS(4), .BITS(16), .CLK_DIV(1), .AUTO_PERIOD(0)) dut_b (
      .clk(clk), .reset(b_reset), .start(b_start), .ack(b_ack), .pad_data(b_pad),
      .pad_latch(b_latch), .pad_clk(b_pclk), .busy(b_busy), .done(b_done),
      .state_flat(b_flat), .changed(b_chg)
   );

   always @(posedge b_pclk or posedge b_latch)
      for (int c = 0; c < 4; c++)
         if (b_latch) b_sh[c] <= b_raw[c];
         else         b_sh[c] <= {1'b1, b_sh[c][15:1]};
   always_comb
      for (int c = 0; c < 4; c++) b_pad[c] = b_sh[c][0];
   always @(negedge b_pclk) b_lo_cnt++;

   // ---------------- instance C: auto polling every 200 cycles ----------------
   logic             c_reset = 1'b0, c_start = 1'b0;
   logic [1:0]       c_ack = '0, c_pad;
   logic             c_latch, c_pclk, c_busy, c_done;
   logic [15:0]      c_flat;
   logic [1:0]       c_chg;
   logic [1:0][7:0]  c_raw = '1;
   logic [1:0][7:0]  c_sh  = '1;

   pad_poller #(.AUTO_PERIOD(200)) dut_c (
      .clk(clk), .reset(c_reset), .start(c_start), .ack(c_ack), .pad_data(c_pad),
      .pad_latch(c_latch), .pad_clk(c_pclk), .busy(c_busy), .done(c_done),
      .state_flat(c_flat), .changed(c_chg)
   );

   always @(posedge c_pclk or posedge c_latch)
      for (int c = 0; c < 2; c++)
         if (c_latch) c_sh[c] <= c_raw[c];
         else         c_sh[c] <= {1'b1, c_sh[c][7:1]};
   assign c_pad = {c_sh[1][0], c_sh[0][0]};

   // ---------------- scoreboard for instance A ----------------
   typedef struct {
      logic [15:0] flat;
      logic [1:0]  chg;
   } exp_t;

   exp_t a_sb[$];
   exp_t a_e;
   int   a_done_cnt  = 0;
   logic a_done_prev = 1'b0;

   // Published state is visible the cycle after the done pulse.
   always @(negedge clk) begin
      if (a_done_prev) begin
         if (a_sb.size() == 0) begin
            flag_fail("a_unexpected_done");
         end else begin
            a_e = a_sb.pop_front();
            check("a_flat", a_flat, a_e.flat);
            check("a_changed", a_chg, a_e.chg);
         end
      end
      if (a_done === 1'b1) a_done_cnt++;
      a_done_prev = (a_done === 1'b1);
   end

   typedef struct {
      logic [7:0]  raw0;
      logic [7:0]  raw1;
      logic [1:0]  ack;
      logic [15:0] flat;
      logic [1:0]  chg;
   } vec_t;

   vec_t tbl [5];

   // Caller sits at a negedge; start covers exactly one posedge.
   // Returns the edge count at which done is high, or -1 on timeout.
   task automatic a_poll(output int lat);
      a_start = 1'b1;
      lat = -1;
      for (int n = 1; n <= 300; n++) begin
         @(negedge clk);
         a_start = 1'b0;
         if (n == 1) check("a_busy_after_start", a_busy, 1'b1);
         if (a_done) begin
            lat = n;
            break;
         end
      end
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin : main
      int lat;
      int gap;
      int cnt0;
      int first, second;
      logic pb, c_chk;
      logic [63:0] b_exp;

      tbl[0] = '{8'hFE, 8'h7F, 2'b00, 16'h8001, 2'b11};
      tbl[1] = '{8'hFE, 8'h7F, 2'b11, 16'h8001, 2'b00};
      tbl[2] = '{8'h00, 8'hFF, 2'b00, 16'h00FF, 2'b11};
      tbl[3] = '{8'h00, 8'hA5, 2'b01, 16'h5AFF, 2'b10};
      tbl[4] = '{8'h3C, 8'hA5, 2'b10, 16'h5AC3, 2'b01};

      a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
      repeat (3) @(negedge clk);
      a_reset = 1'b0; b_reset = 1'b0;

      // reset state
      @(negedge clk);
      check("a_rst_busy", a_busy, 1'b0);
      check("a_rst_latch", a_latch, 1'b0);
      check("a_rst_pclk", a_pclk, 1'b1);
      check("a_rst_flat", a_flat, 16'h0);

      // reset in the middle of a poll
      a_raw[0] = 8'hFE; a_raw[1] = 8'h7F;
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      repeat (49) @(negedge clk);
      check("a_mid_busy", a_busy, 1'b1);
      a_reset = 1'b1;
      #1;
      check("a_midrst_busy", a_busy, 1'b0);
      check("a_midrst_latch", a_latch, 1'b0);
      check("a_midrst_pclk", a_pclk, 1'b1);
      check("a_midrst_done", a_done, 1'b0);
      check("a_midrst_flat", a_flat, 16'h0);
      check("a_midrst_chg", a_chg, 2'b00);
      repeat (3) @(negedge clk);
      a_reset = 1'b0;
      repeat (250) @(negedge clk);
      check("a_no_done_after_rst", a_done_cnt, 0);
      check("a_idle_after_rst", a_busy, 1'b0);
      check("a_flat_after_rst", a_flat, 16'h0);

      // table-driven polls
      for (int i = 0; i < 5; i++) begin
         if (tbl[i].ack != 2'b00) begin
            a_ack = tbl[i].ack;
            @(negedge clk);
            a_ack = 2'b00;
         end
         a_raw[0] = tbl[i].raw0;
         a_raw[1] = tbl[i].raw1;
         a_sb.push_back('{tbl[i].flat, tbl[i].chg});
         a_poll(lat);
         if (lat < 0) begin
            flag_fail("a_poll_timeout");
         end else begin
            check("a_latency", lat, 103);
            check("a_busy_in_finish", a_busy, 1'b0);
         end
         repeat (3) @(negedge clk);
      end

      // three starts during a poll -> exactly one more poll, back to back
      a_sb.push_back('{16'h5AC3, 2'b01});
      a_sb.push_back('{16'h5AC3, 2'b01});
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         repeat (9) @(negedge clk);
         a_start = 1'b1;
         @(negedge clk);
         a_start = 1'b0;
      end
      lat = -1;
      for (int n = 1; n <= 300; n++) begin
         @(negedge clk);
         if (a_done) begin
            lat = n;
            break;
         end
      end
      if (lat < 0) flag_fail("a_b2b_first_timeout");
      gap = -1;
      for (int g = 1; g <= 300; g++) begin
         @(negedge clk);
         if (g == 2) check("a_b2b_busy_restart", a_busy, 1'b1);
         if (a_done) begin
            gap = g;
            break;
         end
      end
      check("a_b2b_gap", gap, 104);
      @(negedge clk);
      cnt0 = a_done_cnt;
      repeat (400) @(negedge clk);
      check("a_b2b_no_third", a_done_cnt - cnt0, 0);
      check("a_b2b_idle", a_busy, 1'b0);
      check("a_sb_empty", a_sb.size(), 0);

      // instance B: 4 channels, 16 bits, divide by 1
      b_raw[0] = 16'h1234; b_raw[1] = 16'hFFFE; b_raw[2] = 16'h8001; b_raw[3] = 16'hA5C3;
      b_lo_cnt = 0;
      b_start = 1'b1;
      lat = -1;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         b_start = 1'b0;
         if (b_done) begin
            lat = n;
            break;
         end
      end
      check("b_latency", lat, 34);
      check("b_clk_pulses", b_lo_cnt, 15);
      @(negedge clk);
      for (int c = 0; c < 4; c++) b_exp[c*16 +: 16] = ~b_raw[c];
      check("b_flat", b_flat, b_exp);
      check("b_changed", b_chg, 4'hF);

      // instance C: auto polling, ack colliding with a change
      c_raw[0] = 8'hFE; c_raw[1] = 8'h7F;
      c_reset = 1'b0;
      first = -1; second = -1; pb = 1'b0; c_chk = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (c_busy && !pb) begin
            if (first < 0) begin
               first = k;
            end else begin
               second = k;
               break;
            end
         end
         pb = c_busy;
         if (c_chk) begin
            check("c_flat_first", c_flat, 16'h8001);
            check("c_changed_first", c_chg, 2'b11);
            c_chk = 1'b0;
         end
         if (c_done && first >= 0) begin
            c_chk = 1'b1;
            c_raw[0] = 8'h00;
            c_raw[1] = 8'hFF;
         end
      end
      check("c_first_poll_edge", first, 199);
      check("c_second_poll_edge", second, 399);
      lat = -1;
      for (int n = 1; n <= 300; n++) begin
         @(negedge clk);
         if (c_done) begin
            lat = n;
            break;
         end
      end
      if (lat < 0) begin
         flag_fail("c_second_timeout");
      end else begin
         c_ack = 2'b11;
         @(negedge clk);
         c_ack = 2'b00;
         check("c_set_wins_over_ack", c_chg, 2'b11);
         check("c_flat_second", c_flat, 16'h00FF);
         c_ack = 2'b11;
         @(negedge clk);
         c_ack = 2'b00;
         check("c_ack_clears", c_chg, 2'b00);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
